// File: rtl/fetch_ring_queue.sv
// Purpose : circular-buffer instruction queue between the fetch unit and the decoder.
// Latency : a push at edge N is visible on out_data after edge N; no empty bypass.
// Backpres: in_ready drops only at full; a pop at full does not free a same-cycle push slot.
//
// Ports:
//   clk, reset            - rising-edge clock, asynchronous active-high reset
//   flush                 - discard all contents (priority over push/pop)
//   in_valid/in_ready     - producer handshake, in_data is the pushed entry
//   out_pop               - 0 none, 1 one entry, 2 two entries, 3 treated as none
//   out_valid/out_data    - oldest entry
//   out_valid_next/_data  - second-oldest entry (for two-entry decode)
//   count, almost_full    - occupancy and threshold flag
//   underflow_err         - sticky over-pop flag, cleared by err_clear (set wins)
module fetch_ring_queue #(
    parameter int DEPTH        = 8,
    parameter int WIDTH        = 32,
    parameter int AFULL_THRESH = 6
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    input  logic [1:0]                   out_pop,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_valid_next,
    output logic [WIDTH-1:0]             out_data_next,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         almost_full,
    output logic                         underflow_err,
    input  logic                         err_clear
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_underflow_err;

    logic [1:0]       w_req;
    logic [CW-1:0]    w_pop_n;
    logic             w_over_pop;
    logic             w_in_ready;
    logic             w_push;
    logic [PW-1:0]    w_rd_ptr_nx;

    // Reserved encoding 3 behaves as no request.
    always_comb begin
        w_req = 2'd0;
        case (out_pop)
            2'd1:    w_req = 2'd1;
            2'd2:    w_req = 2'd2;
            default: w_req = 2'd0;
        endcase
    end

    // Pop is clamped to the pre-edge occupancy so the read pointer can never
    // overtake the write pointer; the excess only raises the error flag.
    always_comb begin
        w_pop_n = CW'(w_req);
        if (CW'(w_req) > r_count)
            w_pop_n = r_count;
    end

    assign w_over_pop  = ~flush & (CW'(w_req) > r_count);
    assign w_in_ready  = (r_count != CW'(DEPTH));
    assign w_push      = in_valid & w_in_ready & ~flush;
    assign w_rd_ptr_nx = r_rd_ptr + PW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_underflow_err <= 1'b0;
        end else begin
            if (flush) begin
                r_rd_ptr <= r_wr_ptr;
                r_count  <= '0;
            end else begin
                if (w_push)
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                // Truncation to PW bits gives the modulo-DEPTH advance.
                r_rd_ptr <= r_rd_ptr + PW'(w_pop_n);
                r_count  <= r_count + CW'(w_push) - w_pop_n;
            end

            if (w_over_pop)
                r_underflow_err <= 1'b1;
            else if (err_clear)
                r_underflow_err <= 1'b0;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= in_data;
    end

    assign in_ready       = w_in_ready;
    assign out_valid      = (r_count != '0);
    assign out_valid_next = (r_count >= CW'(2));
    assign out_data       = r_mem[r_rd_ptr];
    assign out_data_next  = r_mem[w_rd_ptr_nx];
    assign count          = r_count;
    assign almost_full    = (r_count >= CW'(AFULL_THRESH));
    assign underflow_err  = r_underflow_err;

endmodule
